// File: rtl/core8_mem_copy_master_if.sv
// Avalon-MM bus between the copy master and a fixed-latency memory slave.
// There is no waitrequest and no readdatavalid: read data arrives a fixed number of cycles after the read.
interface core8_mem_copy_master_if #(
   parameter int unsigned ADDR_W = 13,
   parameter int unsigned DATA_W = 32
);
   logic [ADDR_W-1:0]   avm_address;
   logic [DATA_W/8-1:0] avm_byteenable;
   logic                avm_chipselect;
   logic                avm_write;
   logic [DATA_W-1:0]   avm_writedata;
   logic [DATA_W-1:0]   avm_readdata;

   modport master (
      output avm_address,
      output avm_byteenable,
      output avm_chipselect,
      output avm_write,
      output avm_writedata,
      input  avm_readdata
   );

   modport slave (
      input  avm_address,
      input  avm_byteenable,
      input  avm_chipselect,
      input  avm_write,
      input  avm_writedata,
      output avm_readdata
   );
endinterface

// File: rtl/core8_mem_copy_master.sv
// Word-by-word forward memory copy over an Avalon-MM master with fixed read latency.
// Each word costs RD (1) + WAIT (READ_LATENCY) + WR (1) cycles.
// Optional macro CORE8_COPY_CHECKSUM_EN adds a running sum of the written words on checksum_o.
// When the macro is not defined, checksum_o is tied to zero.
module core8_mem_copy_master #(
   parameter int unsigned ADDR_W       = 13,
   parameter int unsigned DATA_W       = 32,
   parameter int unsigned READ_LATENCY = 1
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic                start_i,
   input  logic                abort_i,
   input  logic [ADDR_W-1:0]   src_addr_i,
   input  logic [ADDR_W-1:0]   dst_addr_i,
   input  logic [ADDR_W:0]     length_i,
   output logic                busy_o,
   output logic                done_o,
   output logic                aborted_o,
   output logic [DATA_W-1:0]   checksum_o,
   core8_mem_copy_master_if.master avm
);

   typedef enum logic [2:0] {StIdle, StRd, StWait, StWr, StDone} state_e;

   localparam logic [1:0]    WaitLast = 2'(READ_LATENCY - 1);
   localparam logic [ADDR_W:0] RemOne = (ADDR_W+1)'(1);

   state_e              state_q, state_d;
   logic [ADDR_W-1:0]   src_q, src_d;
   logic [ADDR_W-1:0]   dst_q, dst_d;
   logic [ADDR_W:0]     rem_q, rem_d;
   logic [DATA_W-1:0]   data_q, data_d;
   logic [1:0]          wait_q, wait_d;
   logic                aborted_q, aborted_d;

   // State and datapath registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= StIdle;
         src_q     <= '0;
         dst_q     <= '0;
         rem_q     <= '0;
         data_q    <= '0;
         wait_q    <= '0;
         aborted_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         src_q     <= src_d;
         dst_q     <= dst_d;
         rem_q     <= rem_d;
         data_q    <= data_d;
         wait_q    <= wait_d;
         aborted_q <= aborted_d;
      end
   end

   // Next state and bus outputs; bus is zero outside RD/WR so reset forces it to zero.
   always_comb begin
      state_d            = state_q;
      src_d              = src_q;
      dst_d              = dst_q;
      rem_d              = rem_q;
      data_d             = data_q;
      wait_d             = wait_q;
      aborted_d          = 1'b0;
      avm.avm_chipselect = 1'b0;
      avm.avm_write      = 1'b0;
      avm.avm_address    = '0;
      avm.avm_writedata  = '0;
      avm.avm_byteenable = '0;
      busy_o             = (state_q != StIdle);
      done_o             = (state_q == StDone);
      aborted_o          = aborted_q;

      unique case (state_q)
         StIdle: begin
            // abort is ignored here, so start wins when both are high
            if (start_i) begin
               src_d   = src_addr_i;
               dst_d   = dst_addr_i;
               rem_d   = length_i;
               state_d = (length_i == '0) ? StDone : StRd;
            end
         end
         StRd: begin
            avm.avm_chipselect = 1'b1;
            avm.avm_address    = src_q;
            wait_d             = '0;
            if (abort_i) begin
               state_d   = StIdle;
               aborted_d = 1'b1;
            end else begin
               state_d = StWait;
            end
         end
         StWait: begin
            if (abort_i) begin
               state_d   = StIdle;
               aborted_d = 1'b1;
            end else if (wait_q == WaitLast) begin
               data_d  = avm.avm_readdata;
               state_d = StWr;
            end else begin
               wait_d = wait_q + 2'd1;
            end
         end
         StWr: begin
            // The write goes out even if abort arrives in this cycle.
            avm.avm_chipselect = 1'b1;
            avm.avm_write      = 1'b1;
            avm.avm_address    = dst_q;
            avm.avm_writedata  = data_q;
            avm.avm_byteenable = '1;
            if (abort_i) begin
               state_d   = StIdle;
               aborted_d = 1'b1;
            end else begin
               src_d   = src_q + ADDR_W'(1);
               dst_d   = dst_q + ADDR_W'(1);
               rem_d   = rem_q - RemOne;
               state_d = (rem_q == RemOne) ? StDone : StRd;
            end
         end
         StDone: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

`ifdef CORE8_COPY_CHECKSUM_EN
   logic [DATA_W-1:0] sum_q;

   // Running sum: cleared on an accepted start, accumulates each word written in WR.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sum_q <= '0;
      end else if (state_q == StIdle && start_i) begin
         sum_q <= '0;
      end else if (state_q == StWr) begin
         sum_q <= sum_q + data_q;
      end
   end

   assign checksum_o = sum_q;
`else
   assign checksum_o = '0;
`endif

endmodule
